// File: rtl/boa_pmu_ctrl_if.sv
// pmu_bus: CPU-side PMU register requests (reset / shutdown) into the power controller.
// Latency: none, plain level wires synchronous to the controller clock.
// Backpressure: none; the requests are levels that the controller samples every cycle.
//
// Signals:
//   rst  - software reset request, level
//   shdn - shutdown request, level
interface pmu_bus;
  logic rst;
  logic shdn;

  modport PMU (input rst, input shdn);
  modport CPU (output rst, output shdn);
endinterface

// File: rtl/boa_pmu_ctrl.sv
// boa_pmu_ctrl: power/reset sequencer (RESET -> RUN -> SHDN -> OFF) with reset-cause capture.
// Latency: RUN requests reach sys_rst one edge after sampling; ext_rst adds 2 synchronizer edges.
// Backpressure: none; requests are levels, ignored outside RUN, and OFF is left only by rst.
//
// Ports:
//   clk       - CPU clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset, restarts the power-on sequence
//   pmb       - pmu_bus.PMU: software reset / shutdown request levels
//   ext_rst   - external reset button, asynchronous, active-high
//   pwr_good  - supply-good indication, synchronous to clk
//   sys_rst   - registered system reset, active-high
//   pwr_en    - registered supply enable, active-high
//   state     - current state (0 RESET, 1 RUN, 2 SHDN, 3 OFF)
//   rst_cause - cause of the last entry to RESET (0 POR, 1 SW, 2 EXT, 3 BROWNOUT)
module boa_pmu_ctrl #(
  parameter int RST_HOLD   = 16,
  parameter int SHDN_DELAY = 256
) (
  input  logic       clk,
  input  logic       rst,
  pmu_bus.PMU        pmb,
  input  logic       ext_rst,
  input  logic       pwr_good,
  output logic       sys_rst,
  output logic       pwr_en,
  output logic [1:0] state,
  output logic [1:0] rst_cause
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_SHDN  = 2'd2;
  localparam logic [1:0] ST_OFF   = 2'd3;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_SW   = 2'd1;
  localparam logic [1:0] CAUSE_EXT  = 2'd2;
  localparam logic [1:0] CAUSE_BROWN = 2'd3;

  // Counter loads are the parameter minus one, truncated to the counter width,
  // so a count of N loads N-1 and the terminal compare is against zero.
  localparam logic [15:0] RST_LOAD  = 16'(RST_HOLD - 1);
  localparam logic [15:0] SHDN_LOAD = 16'(SHDN_DELAY - 1);

  logic        ext_q1;
  logic        ext_s;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic [1:0]  state_n;
  logic [1:0]  cause_n;

  // Two-flop synchronizer for the asynchronous reset button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_q1 <= 1'b0;
      ext_s  <= 1'b0;
    end else begin
      ext_q1 <= ext_rst;
      ext_s  <= ext_q1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cause_n = rst_cause;
    case (state)
      ST_RESET: begin
        // Hold time restarts whenever supply or button is not quiet, so RUN
        // needs RST_HOLD consecutive good cycles.
        if (!pwr_good || ext_s) begin
          cnt_n = RST_LOAD;
        end else if (cnt == 16'd0) begin
          state_n = ST_RUN;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      ST_RUN: begin
        // Priority: shutdown > brownout > software reset > external reset.
        // Shutdown does not touch rst_cause since it is not a RESET entry.
        if (pmb.shdn) begin
          state_n = ST_SHDN;
          cnt_n   = SHDN_LOAD;
        end else if (!pwr_good) begin
          state_n = ST_RESET;
          cnt_n   = RST_LOAD;
          cause_n = CAUSE_BROWN;
        end else if (pmb.rst) begin
          state_n = ST_RESET;
          cnt_n   = RST_LOAD;
          cause_n = CAUSE_SW;
        end else if (ext_s) begin
          state_n = ST_RESET;
          cnt_n   = RST_LOAD;
          cause_n = CAUSE_EXT;
        end
      end
      ST_SHDN: begin
        if (cnt == 16'd0) begin
          state_n = ST_OFF;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: begin
        // OFF is terminal until the asynchronous reset.
        state_n = ST_OFF;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as state, with no combinational path from any input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RESET;
      cnt       <= RST_LOAD;
      rst_cause <= CAUSE_POR;
      sys_rst   <= 1'b1;
      pwr_en    <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rst_cause <= cause_n;
      sys_rst   <= (state_n != ST_RUN);
      pwr_en    <= (state_n != ST_OFF);
    end
  end

endmodule

// File: tb/tb_boa_pmu_ctrl.sv
module tb_boa_pmu_ctrl;

  logic       clk;
  logic       rst;
  logic       ext_rst;
  logic       pwr_good;
  logic       sys_rst;
  logic       pwr_en;
  logic [1:0] state;
  logic [1:0] rst_cause;

  int ncmp;
  int nerr;

  pmu_bus pmb_if ();

  boa_pmu_ctrl #(
    .RST_HOLD   (4),
    .SHDN_DELAY (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pmb       (pmb_if),
    .ext_rst   (ext_rst),
    .pwr_good  (pwr_good),
    .sys_rst   (sys_rst),
    .pwr_en    (pwr_en),
    .state     (state),
    .rst_cause (rst_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic sr,
                         input logic pe, input logic [1:0] rc);
    check({tag, ".state"}, state, st);
    check({tag, ".sys_rst"}, {1'b0, sys_rst}, {1'b0, sr});
    check({tag, ".pwr_en"}, {1'b0, pwr_en}, {1'b0, pe});
    check({tag, ".cause"}, rst_cause, rc);
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst         = 1'b1;
    ext_rst     = 1'b0;
    pwr_good    = 1'b1;
    pmb_if.rst  = 1'b0;
    pmb_if.shdn = 1'b0;

    // Reset state
    step(2);
    chk_all("por_hold", 2'd0, 1'b1, 1'b1, 2'd0);

    // POR: sys_rst falls on the 4th edge after release
    rst = 1'b0;
    step(3);
    chk_all("por_e3", 2'd0, 1'b1, 1'b1, 2'd0);
    step(1);
    chk_all("por_e4", 2'd1, 1'b0, 1'b1, 2'd0);

    // Software reset, one-cycle pulse
    pmb_if.rst = 1'b1;
    step(1);
    pmb_if.rst = 1'b0;
    chk_all("sw_entry", 2'd0, 1'b1, 1'b1, 2'd1);
    step(3);
    chk_all("sw_e3", 2'd0, 1'b1, 1'b1, 2'd1);
    step(1);
    chk_all("sw_run", 2'd1, 1'b0, 1'b1, 2'd1);

    // Brownout: pwr_good low for 3 cycles
    pwr_good = 1'b0;
    step(1);
    chk_all("bo_entry", 2'd0, 1'b1, 1'b1, 2'd3);
    step(2);
    pwr_good = 1'b1;
    step(3);
    chk_all("bo_good3", 2'd0, 1'b1, 1'b1, 2'd3);
    step(1);
    chk_all("bo_run", 2'd1, 1'b0, 1'b1, 2'd3);

    // External reset held 20 cycles
    ext_rst = 1'b1;
    step(2);
    chk_all("ext_sync", 2'd1, 1'b0, 1'b1, 2'd3);
    step(1);
    chk_all("ext_entry", 2'd0, 1'b1, 1'b1, 2'd2);
    step(17);
    ext_rst = 1'b0;
    step(5);
    chk_all("ext_hold", 2'd0, 1'b1, 1'b1, 2'd2);
    step(1);
    chk_all("ext_run", 2'd1, 1'b0, 1'b1, 2'd2);

    // Priority: brownout beats software reset
    pwr_good   = 1'b0;
    pmb_if.rst = 1'b1;
    step(1);
    pwr_good   = 1'b1;
    pmb_if.rst = 1'b0;
    chk_all("pri_bo_sw", 2'd0, 1'b1, 1'b1, 2'd3);
    step(4);
    chk_all("pri_bo_run", 2'd1, 1'b0, 1'b1, 2'd3);

    // Priority: software reset beats synchronized external reset
    ext_rst = 1'b1;
    step(2);
    pmb_if.rst = 1'b1;
    step(1);
    pmb_if.rst = 1'b0;
    ext_rst    = 1'b0;
    chk_all("pri_sw_ext", 2'd0, 1'b1, 1'b1, 2'd1);
    step(5);
    chk_all("pri_sw_hold", 2'd0, 1'b1, 1'b1, 2'd1);
    step(1);
    chk_all("pri_sw_run", 2'd1, 1'b0, 1'b1, 2'd1);

    // Shutdown with simultaneous rst request; cause unchanged
    pmb_if.shdn = 1'b1;
    pmb_if.rst  = 1'b1;
    step(1);
    chk_all("shdn_entry", 2'd2, 1'b1, 1'b1, 2'd1);
    // Activity during SHDN is ignored
    pmb_if.shdn = 1'b0;
    pwr_good    = 1'b0;
    ext_rst     = 1'b1;
    step(6);
    chk_all("shdn_e7", 2'd2, 1'b1, 1'b1, 2'd1);
    step(1);
    chk_all("shdn_e8m1", 2'd2, 1'b1, 1'b1, 2'd1);
    step(1);
    chk_all("off_entry", 2'd3, 1'b1, 1'b0, 2'd1);

    // Activity in OFF is ignored
    pwr_good    = 1'b1;
    pmb_if.shdn = 1'b1;
    pmb_if.rst  = 1'b0;
    ext_rst     = 1'b0;
    step(5);
    chk_all("off_hold", 2'd3, 1'b1, 1'b0, 2'd1);
    pmb_if.shdn = 1'b0;
    step(1);

    // Async reset between edges in OFF
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 1'b1, 1'b1, 2'd0);
    rst = 1'b0;
    step(3);
    chk_all("por2_e3", 2'd0, 1'b1, 1'b1, 2'd0);
    step(1);
    chk_all("por2_run", 2'd1, 1'b0, 1'b1, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/boa_pmu_ctrl.md
BOA_PMU_CTRL -- requirements
Module: boa_pmu_ctrl

Interface
REQ-001 The block SHALL have parameter RST_HOLD, default 16: cycles sys_rst stays asserted after power-good is stable (legal range 1..65535).
REQ-002 The block SHALL have parameter SHDN_DELAY, default 256: cycles between shutdown request and pwr_en deassertion (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: CPU clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port pmb, pmu_bus.PMU interface: rst and shdn requests from the CPU-side PMU register, level, synchronous to clk.
REQ-006 The block SHALL have port ext_rst, input, 1 bit: external reset button, active-high, asynchronous to clk.
REQ-007 The block SHALL have port pwr_good, input, 1 bit: supply-good indication, synchronous to clk.
REQ-008 The block SHALL have port sys_rst, output, 1 bit: registered system reset to CPU and peripherals, active-high.
REQ-009 The block SHALL have port pwr_en, output, 1 bit: registered supply enable, active-high.
REQ-010 The block SHALL have port state, output, 2 bits: current FSM state (0 RESET, 1 RUN, 2 SHDN, 3 OFF).
REQ-011 The block SHALL have port rst_cause, output, 2 bits: cause of the last entry to RESET (0 POR, 1 SW, 2 EXT, 3 BROWNOUT).

Function
REQ-012 ext_rst SHALL pass a 2-flop synchronizer; the synchronized level (ext_s) SHALL be used everywhere below.
REQ-013 The FSM SHALL have exactly four states: RESET, RUN, SHDN and OFF.
REQ-014 A down-counter cnt SHALL be 16 bits wide; loads SHALL be parameter-1 truncated to 16 bits.
REQ-015 In RESET: sys_rst=1, pwr_en=1; cnt decrements each cycle pwr_good=1 and ext_s=0.
REQ-016 In RESET, pwr_good=0 or ext_s=1 SHALL reload cnt to RST_HOLD-1.
REQ-017 In RESET, when cnt==0, pwr_good=1 and ext_s=0, the next state SHALL be RUN, giving exactly RST_HOLD cycles of sys_rst with stable pwr_good.
REQ-018 In RESET, pmb.rst and pmb.shdn SHALL be ignored.
REQ-019 In RUN: sys_rst=0, pwr_en=1; requests are evaluated each cycle in priority order pmb.shdn > !pwr_good > pmb.rst > ext_s.
REQ-020 In RUN, pmb.shdn SHALL transition to SHDN and load cnt=SHDN_DELAY-1.
REQ-021 In RUN, pwr_good=0 SHALL transition to RESET with rst_cause=3.
REQ-022 In RUN, pmb.rst SHALL transition to RESET with rst_cause=1.
REQ-023 In RUN, ext_s SHALL transition to RESET with rst_cause=2.
REQ-024 Every entry to RESET SHALL load cnt=RST_HOLD-1.
REQ-025 The latency from a request sampled in RUN to sys_rst=1 SHALL be 1 cycle (registered); ext_rst adds 2 synchronizer cycles.
REQ-026 In SHDN: sys_rst=1, pwr_en=1; cnt decrements every cycle; all inputs are ignored; at cnt==0 the next state SHALL be OFF.
REQ-027 In OFF: sys_rst=1, pwr_en=0; all inputs are ignored; OFF SHALL be exited only by rst.
REQ-028 pmb.rst and pmb.shdn asserted together in RUN SHALL go to SHDN; rst_cause SHALL be unchanged.
REQ-029 rst_cause SHALL update only on a RUN->RESET transition and SHALL hold its value otherwise.
REQ-030 sys_rst, pwr_en and state SHALL be driven directly from flops with no combinational path from inputs.

Reset
REQ-031 While rst=1, asynchronously: state=RESET, sys_rst=1, pwr_en=1, rst_cause=0, cnt=RST_HOLD-1, synchronizer flops=0.
REQ-032 rst asserted in any state, including mid-SHDN or OFF, SHALL abort the current operation and restart from RESET.
REQ-033 The first clock edge after rst deasserts SHALL begin RESET counting.

Verification (RST_HOLD=4, SHDN_DELAY=8)
REQ-034 POR with pwr_good=1: rst released -> sys_rst falls after exactly 4 clk edges, state=1, rst_cause=0.
REQ-035 Software reset: in RUN, pmb.rst pulse for 1 cycle -> sys_rst=1 next cycle, rst_cause=1, sys_rst low again 4 cycles later.
REQ-036 Shutdown: pmb.shdn and pmb.rst together in RUN -> state=2, pwr_en falls 8 cycles after entry, state=3, rst_cause unchanged; further pmb/ext_rst activity has no effect.
REQ-037 Brownout: pwr_good low for 3 cycles in RUN -> RESET, rst_cause=3, sys_rst held until pwr_good has been high 4 consecutive cycles.
REQ-038 Held ext_rst: ext_rst high for 20 cycles -> RESET 3 cycles after assertion, rst_cause=2, RUN reached 4 cycles after ext_s falls.
REQ-039 Async reset in OFF: rst pulse asserted between clock edges -> pwr_en=1 and state=0 immediately; POR sequence as in REQ-034 follows.
